// File: rtl/olivia_prog_loader.sv
// Olivia program loader: receives a framed byte stream (LEN_HI, LEN_LO,
// 4N instruction bytes MSB first, XOR checksum), writes the instruction
// bytes big-endian into the byte-addressed IM, screens each word against
// the supported LEGv8 opcode set, and holds the core in reset until a
// load completes without error.
module olivia_prog_loader #(
  parameter int IM_BYTES      = 64,
  parameter int ADDR_W        = 6,
  parameter bit CHECK_OPCODES = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [7:0]        im_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [15:0]       loaded_words,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_END
  } state_t;

  state_t state, state_nx;

  logic [7:0]        len_hi;
  logic [ADDR_W-1:0] byte_cnt;
  logic [ADDR_W-1:0] last_idx;
  logic [7:0]        csum;
  logic [23:0]       word_sr;
  logic              bad_op;

  logic              xfer;
  logic [17:0]       n_bytes;
  logic              len_ovf;
  logic              len_zero;
  logic [31:0]       word_full;
  logic              word_bad;

  // Supported LEGv8 opcodes in bits [31:21]
  function automatic logic op_supported(input logic [10:0] op);
    case (op)
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
      11'b11111000010, 11'b11111000000, 11'b10110100000, 11'b00010100000:
        op_supported = 1'b1;
      default:
        op_supported = 1'b0;
    endcase
  endfunction

  // Handshake, length decode and word screening
  always_comb begin
    in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                (state == S_DATA)   || (state == S_CSUM);
    busy      = (state != S_IDLE);
    done      = (state == S_END);
    xfer      = in_valid & in_ready;
    n_bytes   = {len_hi, in_data, 2'b00};
    len_ovf   = (n_bytes > 18'(IM_BYTES));
    len_zero  = ({len_hi, in_data} == 16'h0000);
    word_full = {word_sr, in_data};
    word_bad  = CHECK_OPCODES && (word_full != 32'h0) &&
                !op_supported(word_full[31:21]);
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_LEN_HI;
      S_LEN_HI: if (xfer)  state_nx = S_LEN_LO;
      S_LEN_LO: if (xfer) begin
                  if (len_ovf)       state_nx = S_END;
                  else if (len_zero) state_nx = S_CSUM;
                  else               state_nx = S_DATA;
                end
      S_DATA:   if (xfer && (byte_cnt == last_idx)) state_nx = S_CSUM;
      S_CSUM:   if (xfer)  state_nx = S_END;
      S_END:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Datapath: IM write port, checksum, word assembly, status
  always_ff @(posedge CLK) begin
    if (!RST) begin
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      err_code     <= '0;
      loaded_words <= '0;
      cpu_hold     <= 1'b1;
      len_hi       <= '0;
      byte_cnt     <= '0;
      last_idx     <= '0;
      csum         <= '0;
      word_sr      <= '0;
      bad_op       <= 1'b0;
    end else begin
      im_we <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          cpu_hold     <= 1'b1;
          err_code     <= '0;
          loaded_words <= '0;
          bad_op       <= 1'b0;
          csum         <= '0;
          byte_cnt     <= '0;
        end
        S_LEN_HI: if (xfer) len_hi <= in_data;
        S_LEN_LO: if (xfer) begin
          if (len_ovf) err_code <= 2'd1;
          // 4N-1 fits ADDR_W bits whenever the length check passes
          else         last_idx <= n_bytes[ADDR_W-1:0] - ADDR_W'(1);
        end
        S_DATA: if (xfer) begin
          im_we    <= 1'b1;
          im_addr  <= byte_cnt;
          im_wdata <= in_data;
          csum     <= csum ^ in_data;
          word_sr  <= {word_sr[15:0], in_data};
          byte_cnt <= byte_cnt + ADDR_W'(1);
          if (byte_cnt[1:0] == 2'd3) begin
            loaded_words <= loaded_words + 16'd1;
            if (word_bad) bad_op <= 1'b1;
          end
        end
        S_CSUM: if (xfer) begin
          if (in_data != csum) err_code <= 2'd2;
          else if (bad_op)     err_code <= 2'd3;
          else                 err_code <= 2'd0;
        end
        S_END: if (err_code == 2'd0) cpu_hold <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_olivia_prog_loader.sv
// Directed bench for olivia_prog_loader: two instances share the stimulus,
// one with opcode checking enabled and one with it disabled.
module tb_olivia_prog_loader;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic        a_in_ready, a_im_we, a_busy, a_done, a_cpu_hold;
  logic [5:0]  a_im_addr;
  logic [7:0]  a_im_wdata;
  logic [1:0]  a_err;
  logic [15:0] a_loaded;

  logic        b_in_ready, b_im_we, b_busy, b_done, b_cpu_hold;
  logic [5:0]  b_im_addr;
  logic [7:0]  b_im_wdata;
  logic [1:0]  b_err;
  logic [15:0] b_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [64];
  int unsigned we_cnt = 0;
  int unsigned we_base;
  int          cyc;
  logic [7:0]  frame [$];

  always #5 CLK = ~CLK;

  olivia_prog_loader #(.IM_BYTES(64), .ADDR_W(6), .CHECK_OPCODES(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .im_we(a_im_we), .im_addr(a_im_addr), .im_wdata(a_im_wdata),
    .busy(a_busy), .done(a_done), .err_code(a_err), .loaded_words(a_loaded),
    .cpu_hold(a_cpu_hold)
  );

  olivia_prog_loader #(.IM_BYTES(64), .ADDR_W(6), .CHECK_OPCODES(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .im_we(b_im_we), .im_addr(b_im_addr), .im_wdata(b_im_wdata),
    .busy(b_busy), .done(b_done), .err_code(b_err), .loaded_words(b_loaded),
    .cpu_hold(b_cpu_hold)
  );

  // IM model fed by the write strobe of the checking instance
  always @(posedge CLK) begin
    if (a_im_we === 1'b1) begin
      mem[a_im_addr] <= a_im_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) @(negedge CLK);
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = b;
    while (!a_in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 64'(t), 64'd0);
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    foreach (frame[i]) send_byte(frame[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_done(output int c);
    c = 0;
    @(negedge CLK);
    while (!a_done && c < 20) begin
      @(negedge CLK);
      c++;
    end
    chk("done_seen", 64'(a_done), 64'd1);
  endtask

  // Called at the done cycle; checks status there and one cycle later
  task automatic check_result(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                              input logic [15:0] ew, input logic ha, input logic hb);
    chk({tag, "_err_a"}, 64'(a_err), 64'(ea));
    chk({tag, "_err_b"}, 64'(b_err), 64'(eb));
    chk({tag, "_words"}, 64'(a_loaded), 64'(ew));
    chk({tag, "_done_b"}, 64'(b_done), 64'd1);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, 64'(a_done), 64'd0);
    chk({tag, "_idle"}, 64'(a_busy), 64'd0);
    chk({tag, "_hold_a"}, 64'(a_cpu_hold), 64'(ha));
    chk({tag, "_hold_b"}, 64'(b_cpu_hold), 64'(hb));
    chk({tag, "_err_held"}, 64'(a_err), 64'(ea));
  endtask

  function automatic logic [63:0] image8();
    return {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]};
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_ready", 64'(a_in_ready), 64'd0);
    chk("rst_we", 64'(a_im_we), 64'd0);
    chk("rst_addr", 64'(a_im_addr), 64'd0);
    chk("rst_wdata", 64'(a_im_wdata), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_words", 64'(a_loaded), 64'd0);
    chk("rst_hold", 64'(a_cpu_hold), 64'd1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_hold", 64'(a_cpu_hold), 64'd1);

    // Case 1: ADD + NOP, good checksum
    we_base = we_cnt;
    pulse_start();
    chk("c1_busy", 64'(a_busy), 64'd1);
    frame = {8'h00, 8'h02, 8'h8B, 8'h02, 8'h00, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA8};
    send_frame(0);
    wait_done(cyc);
    chk("c1_image", image8(), 64'h8B02_0021_0000_0000);
    chk("c1_writes", 64'(we_cnt - we_base), 64'd8);
    check_result("c1", 2'd0, 2'd0, 16'd2, 1'b0, 1'b0);

    // Case 2: same frame, wrong checksum
    we_base = we_cnt;
    pulse_start();
    chk("c2_hold_on_start", 64'(a_cpu_hold), 64'd1);
    frame[10] = 8'hA9;
    send_frame(0);
    wait_done(cyc);
    chk("c2_writes", 64'(we_cnt - we_base), 64'd8);
    chk("c2_image", image8(), 64'h8B02_0021_0000_0000);
    check_result("c2", 2'd2, 2'd2, 16'd2, 1'b1, 1'b1);

    // Case 3: 17 words overflows the 16-word IM
    we_base = we_cnt;
    pulse_start();
    frame = {8'h00, 8'h11};
    send_frame(0);
    wait_done(cyc);
    chk("c3_done_latency", 64'(cyc), 64'd0);
    repeat (3) @(negedge CLK);
    chk("c3_writes", 64'(we_cnt - we_base), 64'd0);
    chk("c3_err", 64'(a_err), 64'd1);
    chk("c3_hold", 64'(a_cpu_hold), 64'd1);
    chk("c3_words", 64'(a_loaded), 64'd0);

    // Case 4: unsupported opcode word
    we_base = we_cnt;
    pulse_start();
    frame = {8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    send_frame(0);
    wait_done(cyc);
    chk("c4_writes", 64'(we_cnt - we_base), 64'd4);
    chk("c4_image", 64'({mem[0], mem[1], mem[2], mem[3]}), 64'hFFFF_FFFF);
    check_result("c4", 2'd3, 2'd0, 16'd1, 1'b1, 1'b0);

    // Case 5: empty program
    we_base = we_cnt;
    pulse_start();
    frame = {8'h00, 8'h00, 8'h00};
    send_frame(0);
    wait_done(cyc);
    chk("c5_writes", 64'(we_cnt - we_base), 64'd0);
    check_result("c5", 2'd0, 2'd0, 16'd0, 1'b0, 1'b0);

    // Case 6: case 1 with random in_valid gaps and a start pulse mid-load
    we_base = we_cnt;
    pulse_start();
    send_byte(8'h00, 2);
    pulse_start();
    frame = {8'h02, 8'h8B, 8'h02, 8'h00, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA8};
    send_frame(3);
    wait_done(cyc);
    chk("c6_writes", 64'(we_cnt - we_base), 64'd8);
    chk("c6_image", image8(), 64'h8B02_0021_0000_0000);
    check_result("c6", 2'd0, 2'd0, 16'd2, 1'b0, 1'b0);

    // Case 7: reset after the third data byte, then a fresh load
    pulse_start();
    frame = {8'h00, 8'h02, 8'h55, 8'h66, 8'h77};
    send_frame(0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("c7_busy", 64'(a_busy), 64'd0);
    chk("c7_hold", 64'(a_cpu_hold), 64'd1);
    chk("c7_ready", 64'(a_in_ready), 64'd0);
    chk("c7_words", 64'(a_loaded), 64'd0);
    we_base = we_cnt;
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    chk("c7_no_writes", 64'(we_cnt - we_base), 64'd0);
    chk("c7_partial", 64'({mem[0], mem[1], mem[2]}), 64'h55_6677);
    we_base = we_cnt;
    pulse_start();
    frame = {8'h00, 8'h02, 8'h8B, 8'h02, 8'h00, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA8};
    send_frame(0);
    wait_done(cyc);
    chk("c7_reload_writes", 64'(we_cnt - we_base), 64'd8);
    chk("c7_reload_image", image8(), 64'h8B02_0021_0000_0000);
    check_result("c7", 2'd0, 2'd0, 16'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
